// File: rtl/regs_dbg_arbiter.sv
// Arbitrates the single register-file write port between core writeback and debug accesses.
// The core always wins; a starved debug access eventually stalls the pipeline through hold_o.
module regs_dbg_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_we_i,
  input  logic [4:0]  core_waddr_i,
  input  logic [31:0] core_wdata_i,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [4:0]  dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  output logic        dbg_ack_o,
  output logic [31:0] dbg_rdata_o,
  output logic        hold_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic [4:0]  rf_raddr_o,
  input  logic [31:0] rf_rdata_i
);

  localparam int CW = $clog2(STARVE_LIMIT + 2);

  typedef enum logic [1:0] {IDLE, PEND, HOLD, ACK} state_t;

  state_t        state, state_next;
  logic [CW-1:0] starve_cnt, starve_cnt_next;
  logic          lat_we;
  logic [4:0]    lat_addr;
  logic [31:0]   lat_wdata;
  logic          access;

  // access marks the one cycle the latched debug request actually uses the port
  always_comb begin
    state_next      = state;
    starve_cnt_next = starve_cnt;
    access          = 1'b0;
    unique case (state)
      IDLE: begin
        if (dbg_req_i) begin
          state_next      = PEND;
          starve_cnt_next = '0;
        end
      end
      PEND: begin
        if (core_we_i) begin
          if (starve_cnt < CW'(STARVE_LIMIT)) starve_cnt_next = starve_cnt + 1'b1;
          if (int'(starve_cnt) + 1 >= STARVE_LIMIT) state_next = HOLD;
        end else begin
          access     = 1'b1;
          state_next = ACK;
        end
      end
      HOLD: begin
        if (!core_we_i) begin
          access     = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        if (!dbg_req_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      state_next      = IDLE;
      starve_cnt_next = '0;
      access          = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      dbg_ack_o   <= 1'b0;
      dbg_rdata_o <= '0;
      hold_o      <= 1'b0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
      if (state == IDLE && dbg_req_i) begin
        lat_we    <= dbg_we_i;
        lat_addr  <= dbg_addr_i;
        lat_wdata <= dbg_wdata_i;
      end
      if (access && !lat_we) dbg_rdata_o <= (lat_addr == 5'd0) ? 32'd0 : rf_rdata_i;
      dbg_ack_o <= (state_next == ACK);
      hold_o    <= (state_next == HOLD);
    end
  end

  // x0 is hardwired zero, so any write aimed at it is dropped regardless of source
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = core_waddr_i;
    rf_wdata_o = core_wdata_i;
    if (core_we_i) begin
      rf_we_o = (core_waddr_i != 5'd0);
    end else if (access && lat_we) begin
      rf_waddr_o = lat_addr;
      rf_wdata_o = lat_wdata;
      rf_we_o    = (lat_addr != 5'd0);
    end
  end

  assign rf_raddr_o = lat_addr;

endmodule

// File: doc/regs_dbg_arbiter.md
REGS_DBG_ARBITER -- requirements
Module: regs_dbg_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: consecutive cycles a pending debug access may be deferred by core writes before the pipeline is held.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 core_we_i  in  1  core writeback write enable.
REQ-005 core_waddr_i  in  5  core writeback register address.
REQ-006 core_wdata_i  in  32  core writeback data.
REQ-007 dbg_req_i  in  1  debug access request; four-phase handshake with dbg_ack_o.
REQ-008 dbg_we_i  in  1  debug access type; 1 = write, 0 = read.
REQ-009 dbg_addr_i  in  5  debug register address.
REQ-010 dbg_wdata_i  in  32  debug write data.
REQ-011 dbg_ack_o  out  1  debug access complete; registered.
REQ-012 dbg_rdata_o  out  32  debug read data; registered, valid while dbg_ack_o=1.
REQ-013 hold_o  out  1  stall request to pipeline; registered.
REQ-014 rf_we_o  out  1  register-file write enable (single write port).
REQ-015 rf_waddr_o  out  5  register-file write address.
REQ-016 rf_wdata_o  out  32  register-file write data.
REQ-017 rf_raddr_o  out  5  register-file debug read address.
REQ-018 rf_rdata_i  in  32  register-file debug read data (combinational read).

Function
REQ-019 The block SHALL implement states IDLE, PEND, HOLD, ACK.
REQ-020 IDLE: on dbg_req_i=1, latch dbg_we_i/dbg_addr_i/dbg_wdata_i, clear starve counter, go PEND; later changes to dbg_* inputs SHALL be ignored until return to IDLE.
REQ-021 Core write SHALL always win the port: when core_we_i=1, rf_we_o/rf_waddr_o/rf_wdata_o combinationally equal core signals, same cycle, zero latency.
REQ-022 rf_we_o SHALL be 0 whenever the selected write address is 0 (x0 never written, core or debug).
REQ-023 PEND with core_we_i=1: access deferred, counter increments; when counter reaches STARVE_LIMIT, go HOLD.
REQ-024 PEND with core_we_i=0: perform access this cycle, go ACK.
REQ-025 Debug write access: rf_we_o=1 (unless latched addr=0), rf_waddr_o=latched addr, rf_wdata_o=latched data, exactly one cycle.
REQ-026 Debug read access: rf_raddr_o=latched addr; dbg_rdata_o registers rf_rdata_i at end of that cycle, or 0 when addr=0.
REQ-027 HOLD: hold_o=1; remain while core_we_i=1; first cycle with core_we_i=0 performs access per REQ-025/026 and goes ACK; hold_o deasserts on entry to ACK.
REQ-028 ACK: dbg_ack_o=1 while dbg_req_i=1; when dbg_req_i=0, dbg_ack_o=0 next cycle and go IDLE; a new request is accepted only from IDLE.
REQ-029 Outside an access cycle rf_raddr_o SHALL equal the latched addr; dbg_rdata_o SHALL hold its last value; a write access SHALL leave dbg_rdata_o unchanged.
REQ-030 Counter SHALL saturate at STARVE_LIMIT, never wrap; STARVE_LIMIT=0 SHALL enter HOLD on first deferred cycle.
REQ-031 Exactly one debug access per handshake; no duplicate write if dbg_req_i stays high in ACK.

Reset
REQ-032 On rst=1: state IDLE, counter 0, latched fields 0, dbg_ack_o=0, dbg_rdata_o=0, hold_o=0.
REQ-033 rst mid-operation (PEND/HOLD) SHALL abort the access with no register write; rst in ACK drops dbg_ack_o next cycle.
REQ-034 rf_we_o SHALL follow core_we_i combinationally during reset (write port owned by core; no debug write).

Verification
REQ-035 Idle core, debug write x5=0xDEADBEEF: req -> one-cycle rf_we_o=1, addr 5, data 0xDEADBEEF in PEND; ack next cycle; ack drops one cycle after req drops.
REQ-036 Debug read x7 with rf_rdata_i=0x12345678 -> dbg_rdata_o=0x12345678 with ack; read x0 -> dbg_rdata_o=0, rf_we_o never 1.
REQ-037 Core writes continuously, STARVE_LIMIT=8, debug write pending -> 8 deferred cycles, hold_o=1, access the first cycle core_we_i=0, hold_o=0 in ACK.
REQ-038 Core write x3 and debug write x4 in same cycle -> x3 written that cycle, x4 written first later idle cycle; never both.
REQ-039 Debug write x0 -> ack returned, rf_we_o stays 0.
REQ-040 rst asserted in HOLD -> hold_o=0, dbg_ack_o=0, no debug write, state IDLE next cycle.
